alu_multiciclo: RTL
===================

ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1, iteration-counter width; derived, never overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operation request present on A, B, sel.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand, or shift amount for shift operations.
REQ-009 sel  input  4  operation code.
REQ-010 out_valid  output  1  result present on C and flags.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 C  output  WIDTH  registered result.
REQ-013 flags  output  5  {illegal, div0, negative, overflow, carry}, bits 4..0.
REQ-014 zero  output  1  C equals 0, registered together with C.

Function
REQ-015 The block SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid=1, latch A, B, sel; single-cycle ops go to DONE next edge; iterative ops (1001, 1010, 1011) go to BUSY.
REQ-017 Single-cycle ops: 0000 A+B; 0001 A-B; 0010 A&B; 0011 A|B; 0100 A^B; 0101 unsigned A<B; 0110 unsigned A>B; 0111 A<<B; 1000 A>>B logical; 1100 A>>>B arithmetic; 1101 signed A<B; 1110 signed A>B.
REQ-018 Comparison results SHALL be zero-extended 1 or 0.
REQ-019 Shifts use the full B value; for B>=WIDTH, logical shifts give 0 and 1100 gives WIDTH copies of A[WIDTH-1].
REQ-020 1001 SHALL give the low WIDTH bits of unsigned A*B by shift-add, one bit per cycle.
REQ-021 1010 SHALL give the unsigned quotient and 1011 the unsigned remainder of A/B by restoring division, one bit per cycle.
REQ-022 BUSY SHALL last exactly WIDTH cycles, counted by a CNTW-bit counter; then DONE.
REQ-023 Latency from the accept edge T: out_valid at T+1 for single-cycle ops, at T+WIDTH+1 for iterative ops.
REQ-024 Divide by zero: skip iteration, DONE at T+1, div0=1; quotient = all ones, remainder = A.
REQ-025 sel 1111: illegal=1, C=0, DONE at T+1.
REQ-026 carry: 0000 carry-out; 0001 borrow (A<B unsigned); 0 for all other ops.
REQ-027 overflow: signed two's-complement overflow for 0000/0001; 0 otherwise.
REQ-028 negative = C[WIDTH-1] for every op; zero = (C==0) for every op.
REQ-029 DONE: C, flags and zero SHALL hold stable until out_ready=1; then go to IDLE next edge.
REQ-030 No request is accepted in the cycle DONE is left; in_valid while not in IDLE is ignored, not queued.
REQ-031 Input changes after the accept edge SHALL NOT affect the result in progress.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE and set C=0, flags=0, zero=1, out_valid=0, counter=0.
REQ-033 rst SHALL override every state, including mid-BUSY and DONE; the pending result is discarded.
REQ-034 In the cycle after reset deasserts, in_ready=1.

Verification
REQ-035 WIDTH=32, A=0x7FFFFFFF, B=1, sel=0000, out_ready=1 -> at T+1 C=0x80000000, overflow=1, negative=1, carry=0, zero=0.
REQ-036 WIDTH=32, A=5, B=7, sel=0001 -> C=0xFFFFFFFE, carry=1, overflow=0; then sel=1101 with A=0xFFFFFFFF, B=1 -> C=1.
REQ-037 WIDTH=8, A=0x0D, B=0x0B, sel=1001 -> out_valid exactly at T+9, C=0x8F; in_ready=0 throughout T+1..T+9.
REQ-038 WIDTH=8, A=200, B=7, sel=1010 -> C=28 at T+9; sel=1011 -> C=4; B=0, sel=1010 -> C=0xFF, div0=1 at T+1.
REQ-039 WIDTH=32, A=0x80000000, B=40, sel=1100 -> C=0xFFFFFFFF; sel=1000 -> C=0; out_ready=0 for 5 cycles -> C held, out_valid held.
REQ-040 WIDTH=8, start sel=1001, assert rst at T+4 -> T+5 in_ready=1, out_valid=0, C=0, zero=1; a new 0000 request then completes normally.

Source files
------------

// File: rtl/alu_multiciclo.sv
`default_nettype none
// ==========================================================================
// alu_multiciclo : handshaked ALU, shift-add multiply and restoring divide
// Revision       : 1.0
// ==========================================================================
module alu_multiciclo #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [4:0]       flags,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0]      c_OP_MUL = 4'b1001;
  localparam logic [3:0]      c_OP_DIV = 4'b1010;
  localparam logic [3:0]      c_OP_REM = 4'b1011;
  localparam logic [CNTW-1:0] c_LAST   = CNTW'(WIDTH - 1);

  state_t           r_state;
  logic [CNTW-1:0]  r_cnt;
  logic [3:0]       r_sel;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_c;
  logic [4:0]       r_flags;
  logic             r_zero;

  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_carry, w_ovf, w_ill, w_div0, w_iter;

  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_dif   = {1'b0, A} - {1'b0, B};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    w_div0  = 1'b0;
    w_iter  = (sel == c_OP_MUL) || (((sel == c_OP_DIV) || (sel == c_OP_REM)) && (B != '0));
    case (sel)
      4'b0000: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        // extended-subtraction top bit is the unsigned borrow
        w_res   = w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: w_res = A & B;
      4'b0011: w_res = A | B;
      4'b0100: w_res = A ^ B;
      4'b0101: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0110: w_res = {{(WIDTH-1){1'b0}}, (A > B)};
      4'b0111: w_res = A << B;
      4'b1000: w_res = A >> B;
      4'b1100: w_res = $unsigned($signed(A) >>> B);
      4'b1101: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1110: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
      4'b1010: begin
        w_div0 = (B == '0);
        w_res  = '1;
      end
      4'b1011: begin
        w_div0 = (B == '0);
        w_res  = A;
      end
      4'b1111: w_ill = 1'b1;
      default: w_res = '0;
    endcase
  end

  logic [WIDTH:0]   w_rsh, w_rdif;
  logic [WIDTH-1:0] w_mul_nxt, w_rem_nxt, w_quo_nxt, w_fin;

  // r_a holds the multiplicand (mul) or the dividend/quotient shift register (div)
  always_comb begin
    w_mul_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
    w_rsh     = {r_acc, r_a[WIDTH-1]};
    w_rdif    = w_rsh - {1'b0, r_b};
    if (!w_rdif[WIDTH]) begin
      w_rem_nxt = w_rdif[WIDTH-1:0];
      w_quo_nxt = {r_a[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_rsh[WIDTH-1:0];
      w_quo_nxt = {r_a[WIDTH-2:0], 1'b0};
    end
    if (r_sel == c_OP_MUL)      w_fin = w_mul_nxt;
    else if (r_sel == c_OP_DIV) w_fin = w_quo_nxt;
    else                        w_fin = w_rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= '0;
      r_flags <= '0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sel <= sel;
            r_a   <= A;
            r_b   <= B;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_iter) begin
              r_state <= BUSY;
            end else begin
              r_state <= DONE;
              r_c     <= w_res;
              r_flags <= {w_ill, w_div0, w_res[WIDTH-1], w_ovf, w_carry};
              r_zero  <= (w_res == '0);
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (r_sel == c_OP_MUL) begin
            r_acc <= w_mul_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_rem_nxt;
            r_a   <= w_quo_nxt;
          end
          if (r_cnt == c_LAST) begin
            r_state <= DONE;
            r_cnt   <= '0;
            r_c     <= w_fin;
            r_flags <= {2'b00, w_fin[WIDTH-1], 2'b00};
            r_zero  <= (w_fin == '0);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign C         = r_c;
  assign flags     = r_flags;
  assign zero      = r_zero;

endmodule
`default_nettype wire
